div_iter_core: RTL

Iterative radix-2 divider core that implements the responder side of the divider's AXI-Stream operand/result interface: two independent operand slave channels (dividend, divisor) and one result master channel. It replaces the vendor divider IP under the `mul&div` wrapper without changing the wrapper's handshake logic. One instance is built per signedness through a parameter, mirroring the existing signed/unsigned pair. It produces one {quotient, remainder} result per accepted operand pair, with fixed latency.

---
 rtl/div_iter_core_pkg.sv | 11 +
 rtl/div_iter_core_operand_buf.sv | 35 +++
 rtl/div_iter_core.sv | 127 ++++++++++++
 3 files changed

// File: rtl/div_iter_core_pkg.sv
// div_iter_core_pkg: shared widths, iteration count, FSM encoding and divide-by-zero quotient
package div_iter_core_pkg;
    localparam int DIV_W     = 32;
    localparam int DIV_ITERS = 32;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;
    localparam logic [DIV_W-1:0] DIV_ZERO_Q = '1;
endpackage

// File: rtl/div_iter_core_operand_buf.sv
// div_operand_buf: one-entry AXI-Stream operand holding register with full flag
//   clk, rst       : clock, asynchronous active-high reset
//   i_tdata/i_tvalid/o_tready : slave channel; o_tready = ~full, forced low in reset
//   i_clr          : consumer took the operand, empties the register
//   o_full/o_data  : holding register state and contents
module div_operand_buf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_tdata,
    input  logic         i_tvalid,
    output logic         o_tready,
    input  logic         i_clr,
    output logic         o_full,
    output logic [W-1:0] o_data
);
    logic         r_full;
    logic [W-1:0] r_data;
    assign o_tready = ~r_full & ~rst;
    assign o_full   = r_full;
    assign o_data   = r_data;
    // A transfer and a clear never coincide: tready is low whenever the register is full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_tvalid && o_tready) begin
            r_full <= 1'b1;
            r_data <= i_tdata;
        end else if (i_clr) begin
            r_full <= 1'b0;
        end
    end
endmodule

// File: rtl/div_iter_core.sv
// div_iter_core: iterative radix-2 restoring divider with AXI-Stream operand/result channels
//   SIGNED         : 1 = two's-complement, 0 = unsigned
//   W              : operand width (32 only)
//   div_clk, reset : clock, asynchronous active-high reset
//   s_axis_dividend_* / s_axis_divisor_* : operand slave channels, one-entry buffered each
//   m_axis_dout_tdata  : {quotient, remainder}, held until the next result
//   m_axis_dout_tvalid : one-cycle result pulse, no backpressure
module div_iter_core
    import div_iter_core_pkg::*;
#(
    parameter int SIGNED = 1,
    parameter int W      = 32
) (
    input  logic           div_clk,
    input  logic           reset,
    input  logic [W-1:0]   s_axis_dividend_tdata,
    input  logic           s_axis_dividend_tvalid,
    output logic           s_axis_dividend_tready,
    input  logic [W-1:0]   s_axis_divisor_tdata,
    input  logic           s_axis_divisor_tvalid,
    output logic           s_axis_divisor_tready,
    output logic [2*W-1:0] m_axis_dout_tdata,
    output logic           m_axis_dout_tvalid
);
    localparam logic [4:0] LAST = 5'(DIV_ITERS - 1);

    div_state_t   r_state, w_state_nxt;
    logic [4:0]   r_cnt;
    logic [W-1:0] r_quo, r_rem, r_div, r_x;
    logic         r_neg_q, r_neg_r, r_zero;
    logic [2*W-1:0] r_dout;

    logic         w_dd_full, w_dv_full, w_both, w_load;
    logic [W-1:0] w_dd_data, w_dv_data;

    div_operand_buf #(.W(W)) u_dividend (
        .clk      (div_clk),
        .rst      (reset),
        .i_tdata  (s_axis_dividend_tdata),
        .i_tvalid (s_axis_dividend_tvalid),
        .o_tready (s_axis_dividend_tready),
        .i_clr    (w_load),
        .o_full   (w_dd_full),
        .o_data   (w_dd_data)
    );

    div_operand_buf #(.W(W)) u_divisor (
        .clk      (div_clk),
        .rst      (reset),
        .i_tdata  (s_axis_divisor_tdata),
        .i_tvalid (s_axis_divisor_tvalid),
        .o_tready (s_axis_divisor_tready),
        .i_clr    (w_load),
        .o_full   (w_dv_full),
        .o_data   (w_dv_data)
    );

    assign w_both = w_dd_full & w_dv_full;

    always_ff @(posedge div_clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // IDLE and DONE both load straight into CALC when a pair is waiting.
    always_comb begin
        w_state_nxt = (r_state == ST_CALC) ? ((r_cnt == LAST) ? ST_DONE : ST_CALC)
                    : (w_load ? ST_CALC : ST_IDLE);
    end

    always_comb begin
        w_load             = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && w_both;
        m_axis_dout_tvalid = (r_state == ST_DONE);
    end

    // Operand magnitudes and signs; unsigned mode never sees a negative operand.
    logic         w_x_neg, w_y_neg;
    logic [W-1:0] w_x_abs, w_y_abs;
    assign w_x_neg = (SIGNED != 0) && w_dd_data[W-1];
    assign w_y_neg = (SIGNED != 0) && w_dv_data[W-1];
    assign w_x_abs = w_x_neg ? -w_dd_data : w_dd_data;
    assign w_y_abs = w_y_neg ? -w_dv_data : w_dv_data;

    // r_quo starts as the dividend and shifts it out MSB-first while quotient bits shift in.
    logic [W:0]   w_part, w_diff;
    logic         w_ge;
    logic [W-1:0] w_rem_nxt, w_quo_nxt, w_q_fix, w_r_fix;
    logic [2*W-1:0] w_res;
    assign w_part    = {r_rem, r_quo[W-1]};
    assign w_diff    = w_part - {1'b0, r_div};
    assign w_ge      = ~w_diff[W];
    assign w_rem_nxt = w_ge ? w_diff[W-1:0] : w_part[W-1:0];
    assign w_quo_nxt = {r_quo[W-2:0], w_ge};
    assign w_q_fix   = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    assign w_r_fix   = r_neg_r ? -w_rem_nxt : w_rem_nxt;
    assign w_res     = r_zero ? {DIV_ZERO_Q, r_x} : {w_q_fix, w_r_fix};

    always_ff @(posedge div_clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_x     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_zero  <= 1'b0;
            r_dout  <= '0;
        end else if (w_load) begin
            r_cnt   <= '0;
            r_quo   <= w_x_abs;
            r_rem   <= '0;
            r_div   <= w_y_abs;
            r_x     <= w_dd_data;
            r_neg_q <= w_x_neg ^ w_y_neg;
            r_neg_r <= w_x_neg;
            r_zero  <= (w_dv_data == '0);
        end else if (r_state == ST_CALC) begin
            r_cnt <= r_cnt + 5'd1;
            r_quo <= w_quo_nxt;
            r_rem <= w_rem_nxt;
            if (r_cnt == LAST) r_dout <= w_res;
        end
    end

    assign m_axis_dout_tdata = r_dout;
endmodule
